// File: rtl/line_err_if.sv
// Bus between the IR sensor interface and the line-error block: one frame of eight
// readings plus line_present in, saturated position error and status flags out.
interface line_err_if;
  logic        IR_vld;
  logic        line_present;
  logic [11:0] IR_R0;
  logic [11:0] IR_R1;
  logic [11:0] IR_R2;
  logic [11:0] IR_R3;
  logic [11:0] IR_L0;
  logic [11:0] IR_L1;
  logic [11:0] IR_L2;
  logic [11:0] IR_L3;
  logic [11:0] err;
  logic        err_vld;
  logic        line_lost;
  logic        ovr;

  modport master (
    output IR_vld, line_present,
    output IR_R0, IR_R1, IR_R2, IR_R3,
    output IR_L0, IR_L1, IR_L2, IR_L3,
    input  err, err_vld, line_lost, ovr
  );

  modport slave (
    input  IR_vld, line_present,
    input  IR_R0, IR_R1, IR_R2, IR_R3,
    input  IR_L0, IR_L1, IR_L2, IR_L3,
    output err, err_vld, line_lost, ovr
  );
endinterface

// File: rtl/line_err.sv
// Weighted right-minus-left line-position error: one sensor pair per cycle into an
// 18-bit accumulator, then floor-divide by 16 and clamp to a 12-bit signed error.
module line_err #(
  parameter int unsigned LOST_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  line_err_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  localparam logic [7:0] LostLimit = 8'(LOST_LIMIT);

  state_e             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic signed [17:0] acc_q, acc_d;
  logic [11:0]        r_q [4];
  logic [11:0]        r_d [4];
  logic [11:0]        l_q [4];
  logic [11:0]        l_d [4];
  logic               lp_q, lp_d;
  logic [11:0]        err_q, err_d;
  logic               err_vld_q, err_vld_d;
  logic               lost_q, lost_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovr_q, ovr_d;

  logic [11:0]        r_sel, l_sel;
  logic signed [12:0] diff;
  logic signed [17:0] diff_ext;
  logic signed [17:0] term;
  logic signed [17:0] acc_shr;
  logic [11:0]        err_sat;
  logic [7:0]         cnt_inc;

  // Operands come only from the captured copies, never from the live bus.
  assign r_sel    = r_q[k_q];
  assign l_sel    = l_q[k_q];
  assign diff     = $signed({1'b0, r_sel}) - $signed({1'b0, l_sel});
  assign diff_ext = {{5{diff[12]}}, diff};
  assign term     = diff_ext <<< k_q;
  assign acc_shr  = acc_q >>> 4;
  assign cnt_inc  = (cnt_q == LostLimit) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    err_sat = acc_shr[11:0];
    if (acc_shr > 18'sd2047) begin
      err_sat = 12'h7FF;
    end else if (acc_shr < -18'sd2048) begin
      err_sat = 12'h800;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    r_d       = r_q;
    l_d       = l_q;
    lp_d      = lp_q;
    err_d     = err_q;
    err_vld_d = 1'b0;
    lost_d    = lost_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.IR_vld) begin
          r_d[0]  = bus.IR_R0;
          r_d[1]  = bus.IR_R1;
          r_d[2]  = bus.IR_R2;
          r_d[3]  = bus.IR_R3;
          l_d[0]  = bus.IR_L0;
          l_d[1]  = bus.IR_L1;
          l_d[2]  = bus.IR_L2;
          l_d[3]  = bus.IR_L3;
          lp_d    = bus.line_present;
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (bus.IR_vld) ovr_d = 1'b1;
        acc_d = acc_q + term;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StOut;
      end
      StOut: begin
        if (bus.IR_vld) ovr_d = 1'b1;
        err_vld_d = 1'b1;
        if (lp_q) begin
          err_d  = err_sat;
          cnt_d  = 8'd0;
          lost_d = 1'b0;
        end else begin
          // err deliberately holds its last value while the line is absent.
          cnt_d  = cnt_inc;
          lost_d = (cnt_inc == LostLimit);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= 2'd0;
      acc_q     <= '0;
      r_q       <= '{default: '0};
      l_q       <= '{default: '0};
      lp_q      <= 1'b0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
      lost_q    <= 1'b0;
      cnt_q     <= 8'd0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      l_q       <= l_d;
      lp_q      <= lp_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
      lost_q    <= lost_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.err       = err_q;
  assign bus.err_vld   = err_vld_q;
  assign bus.line_lost = lost_q;
  assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_line_err.sv
// Directed bench for line_err: a reference model pushes expected err/line_lost per
// frame into a scoreboard, popped and compared on each err_vld pulse.
module tb_line_err;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_err_if bus ();

  line_err #(.LOST_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] err;
    logic        lost;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          vld_cnt = 0;
  logic [11:0] m_err = '0;
  int          m_cnt = 0;
  logic        m_lost = 1'b0;

  always @(negedge clk) if (bus.err_vld === 1'b1) vld_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [47:0] r, input logic [47:0] l, input logic lp);
    int   acc;
    int   sh;
    exp_t e;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += (int'(r[k*12 +: 12]) - int'(l[k*12 +: 12])) <<< k;
    sh = acc >>> 4;
    if (lp) begin
      if (sh > 2047) m_err = 12'h7FF;
      else if (sh < -2048) m_err = 12'h800;
      else m_err = 12'(sh);
      m_cnt  = 0;
      m_lost = 1'b0;
    end else begin
      if (m_cnt < 8) m_cnt++;
      m_lost = (m_cnt == 8);
    end
    e.err  = m_err;
    e.lost = m_lost;
    sb.push_back(e);
  endtask

  // IR_vld is sampled on the edge after the first negedge; inputs are then scrambled.
  task automatic drive(input logic [47:0] r, input logic [47:0] l, input logic lp);
    @(negedge clk);
    {bus.IR_R3, bus.IR_R2, bus.IR_R1, bus.IR_R0} = r;
    {bus.IR_L3, bus.IR_L2, bus.IR_L1, bus.IR_L0} = l;
    bus.line_present = lp;
    bus.IR_vld = 1'b1;
    @(negedge clk);
    bus.IR_vld = 1'b0;
    bus.IR_R0 = 12'($urandom);
    bus.IR_R1 = 12'($urandom);
    bus.IR_R2 = 12'($urandom);
    bus.IR_R3 = 12'($urandom);
    bus.IR_L0 = 12'($urandom);
    bus.IR_L1 = 12'($urandom);
    bus.IR_L2 = 12'($urandom);
    bus.IR_L3 = 12'($urandom);
    bus.line_present = ~lp;
  endtask

  task automatic wait_out(input string tag, input int lat_exp);
    int   lat;
    exp_t e;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.err_vld === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_sbq"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_err"}, bus.err, e.err);
      check({tag, "_lost"}, bus.line_lost, e.lost);
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, bus.err_vld, 1'b0);
  endtask

  task automatic frame(input string tag, input logic [47:0] r, input logic [47:0] l,
                       input logic lp);
    push_exp(r, l, lp);
    drive(r, l, lp);
    wait_out(tag, 5);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.IR_vld = 1'b0;
    bus.line_present = 1'b0;
    {bus.IR_R3, bus.IR_R2, bus.IR_R1, bus.IR_R0} = '0;
    {bus.IR_L3, bus.IR_L2, bus.IR_L1, bus.IR_L0} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_err", bus.err, 12'h000);
    check("rst_vld", bus.err_vld, 1'b0);
    check("rst_lost", bus.line_lost, 1'b0);
    check("rst_ovr", bus.ovr, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    frame("mid",   {4{12'h800}}, {4{12'h800}}, 1'b1);
    frame("r0",    {36'h0, 12'h100}, 48'h0, 1'b1);
    frame("l0",    48'h0, {36'h0, 12'h001}, 1'b1);
    frame("satp",  {12'hFFF, 12'hFFF, 24'h0}, 48'h0, 1'b1);
    frame("satn",  48'h0, {12'hFFF, 12'hFFF, 24'h0}, 1'b1);
    frame("r3",    {12'hFFF, 36'h0}, 48'h0, 1'b1);
    frame("mix",   {12'h123, 12'h456, 12'h789, 12'hABC},
                   {12'hFED, 12'h0BA, 12'h987, 12'h654}, 1'b1);
    check("ovr_idle", bus.ovr, 1'b0);

    // Nine line-absent frames after err=16: err holds, line_lost rises on the 8th.
    frame("r0b",   {36'h0, 12'h100}, 48'h0, 1'b1);
    for (int i = 1; i <= 9; i++) frame($sformatf("absent%0d", i),
                                       {12'h300, 36'h0}, {24'h0, 12'h050, 12'h0}, 1'b0);
    frame("back",  48'h0, {36'h0, 12'h001}, 1'b1);

    // Second IR_vld two cycles into the frame is dropped and latches ovr.
    base = vld_cnt;
    push_exp({36'h0, 12'h100}, 48'h0, 1'b1);
    drive({36'h0, 12'h100}, 48'h0, 1'b1);
    @(negedge clk);
    {bus.IR_R3, bus.IR_R2, bus.IR_R1, bus.IR_R0} = {12'hFFF, 36'h0};
    bus.line_present = 1'b1;
    bus.IR_vld = 1'b1;
    @(negedge clk);
    bus.IR_vld = 1'b0;
    wait_out("ovr_frame", 3);
    check("ovr_set", bus.ovr, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("ovr_pulses", vld_cnt - base, 1);
    check("ovr_sticky", bus.ovr, 1'b1);
    check("ovr_err_held", bus.err, 12'h010);

    for (int i = 1; i <= 8; i++) frame($sformatf("pre_rst%0d", i), 48'h0, 48'h0, 1'b0);
    check("pre_rst_lost", bus.line_lost, 1'b1);

    // Reset during ACC aborts the frame with no err_vld.
    base = vld_cnt;
    drive({36'h0, 12'h200}, 48'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_err", bus.err, 12'h000);
    check("arst_vld", bus.err_vld, 1'b0);
    check("arst_lost", bus.line_lost, 1'b0);
    check("arst_ovr", bus.ovr, 1'b0);
    m_err = '0;
    m_cnt = 0;
    m_lost = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_vld", vld_cnt - base, 0);
    frame("post_rst", {12'h010, 12'h020, 12'h040, 12'h080}, {12'h000, 12'h000, 12'h000, 12'h400},
          1'b1);
    check("post_rst_ovr", bus.ovr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
